// File: rtl/fcc_mem_rd_responder_if.sv
// Bundles the FCC read-port request/beat signals and the SRAM-side read signals
// seen by one fcc_mem_rd_responder instance.
interface fcc_mem_rd_responder_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int SIZE_WIDTH = 13
);
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_start_addr;
  logic [SIZE_WIDTH-1:0]   mem_size_bytes;
  logic                    mem_valid;
  logic [255:0]            mem_data;
  logic                    last;
  logic [4:0]              mem_last_valid;
  logic                    busy;
  logic                    err;
  logic                    sram_rd_en;
  logic [ADDR_WIDTH-6:0]   sram_addr;
  logic [255:0]            sram_rd_data;
  logic                    sram_gnt;

  modport slave (
    input  mem_req, mem_start_addr, mem_size_bytes, sram_rd_data, sram_gnt,
    output mem_valid, mem_data, last, mem_last_valid, busy, err, sram_rd_en, sram_addr
  );

  modport master (
    output mem_req, mem_start_addr, mem_size_bytes, sram_rd_data, sram_gnt,
    input  mem_valid, mem_data, last, mem_last_valid, busy, err, sram_rd_en, sram_addr
  );
endinterface

// File: rtl/fcc_mem_rd_responder.sv
// Serves one FCC read request at a time: issues line reads to a 32-byte-wide SRAM
// under an external grant and returns each line as one registered beat.
module fcc_mem_rd_responder #(
  parameter int ADDR_WIDTH = 19,
  parameter int SIZE_WIDTH = 13,
  parameter int LINE_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fcc_mem_rd_responder_if.slave  bus
);

  localparam int OFFS = $clog2(LINE_BYTES);
  localparam int LW   = ADDR_WIDTH - OFFS;
  localparam int CW   = SIZE_WIDTH - OFFS + 1;
  localparam int DW   = 8 * LINE_BYTES;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     line_q, line_d;
  logic [CW-1:0]     lines_q, lines_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [OFFS-1:0]   lv_q, lv_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic              last_q, last_d;
  logic [OFFS-1:0]   mlv_q, mlv_d;

  logic              rd_en;
  logic              final_issue;
  logic              size_zero;
  logic              misaligned;
  logic [CW-1:0]     lines_calc;
  logic [OFFS-1:0]   lv_calc;
  logic [DW-1:0]     masked_data;

  assign size_zero   = (bus.mem_size_bytes == '0);
  assign misaligned  = (bus.mem_start_addr[OFFS-1:0] != '0);
  // Ceiling division by the line size without a wide adder.
  assign lines_calc  = CW'(bus.mem_size_bytes[SIZE_WIDTH-1:OFFS]) + CW'(|bus.mem_size_bytes[OFFS-1:0]);
  assign lv_calc     = bus.mem_size_bytes[OFFS-1:0] - OFFS'(1);
  assign final_issue = (issued_q == lines_q - CW'(1));
  assign rd_en       = (state_q == ISSUE) && bus.sram_gnt;

  // Bytes beyond the last valid index of the final line are zeroed.
  generate
    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_mask
      assign masked_data[8*gi +: 8] = (OFFS'(gi) <= lv_q) ? bus.sram_rd_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    lines_d   = lines_q;
    issued_d  = issued_q;
    lv_d      = lv_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    rd_pend_d = rd_en;
    rd_last_d = rd_en && final_issue;
    valid_d   = rd_pend_q;
    data_d    = '0;
    last_d    = 1'b0;
    mlv_d     = '0;

    if (rd_pend_q) begin
      data_d = rd_last_q ? masked_data : bus.sram_rd_data;
      last_d = rd_last_q;
      mlv_d  = rd_last_q ? lv_q : OFFS'(LINE_BYTES - 1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          err_d = size_zero || misaligned;
          if (!size_zero) begin
            line_d   = bus.mem_start_addr[ADDR_WIDTH-1:OFFS];
            lines_d  = lines_calc;
            lv_d     = lv_calc;
            issued_d = '0;
            busy_d   = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rd_en) begin
          issued_d = issued_q + CW'(1);
          if (final_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_pend_q && rd_last_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      lines_q   <= '0;
      issued_q  <= '0;
      lv_q      <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      mlv_q     <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      lines_q   <= lines_d;
      issued_q  <= issued_d;
      lv_q      <= lv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      mlv_q     <= mlv_d;
    end
  end

  assign bus.sram_rd_en     = rd_en;
  assign bus.sram_addr      = (state_q == ISSUE) ? line_q + LW'(issued_q) : '0;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_data       = data_q;
  assign bus.last           = last_q;
  assign bus.mem_last_valid = mlv_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_fcc_mem_rd_responder.sv
// Randomized scoreboard bench for fcc_mem_rd_responder with a line-level memory
// model, directed corner transfers and a reset-mid-transfer scenario.
module tb_fcc_mem_rd_responder;
  localparam int AW = 19;
  localparam int SW = 13;

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [4:0]   lv;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fcc_mem_rd_responder_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) bus ();

  fcc_mem_rd_responder #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .LINE_BYTES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_beats[$];
  logic [13:0] exp_addrs[$];
  logic        gnt_pat[$];
  logic        fixed_pat[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every byte has its top bit set so that masking to zero is always visible.
  function automatic logic [255:0] line_data(input logic [13:0] a);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) begin
      d[8*k +: 8] = 8'h80 | 8'((int'(a) * 7 + k * 13) ^ (int'(a) >> 5));
    end
    return d;
  endfunction

  // Expected SRAM addresses for all lines and the first n_beats returned beats.
  task automatic push_expect(input logic [13:0] base, input int size, input int n_beats);
    int    lines;
    int    lv;
    beat_t b;
    lines = (size + 31) / 32;
    lv    = (size - 1) % 32;
    for (int i = 0; i < lines; i++) begin
      exp_addrs.push_back(base + 14'(i));
      if (i < n_beats) begin
        b.data = line_data(base + 14'(i));
        b.last = (i == lines - 1);
        b.lv   = b.last ? 5'(lv) : 5'd31;
        if (b.last) begin
          for (int k = lv + 1; k < 32; k++) b.data[8*k +: 8] = 8'h00;
        end
        exp_beats.push_back(b);
      end
    end
  endtask

  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_rd_data <= line_data(bus.sram_addr);
  end

  initial begin
    bus.sram_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.sram_gnt = (gnt_pat.size() > 0) ? gnt_pat.pop_front() : 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    beat_t e;
    logic [13:0] ea;
    if (rst_n) begin
      if (bus.mem_valid) begin
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %h expected no beat", bus.mem_data);
        end else begin
          e = exp_beats.pop_front();
          chk("beat_data", bus.mem_data, e.data);
          chk("beat_last", bus.last, e.last);
          chk("beat_lv", bus.mem_last_valid, e.lv);
        end
      end else begin
        chk("idle_data", bus.mem_data, 256'd0);
        chk("idle_last_lv", {bus.last, bus.mem_last_valid}, 6'd0);
      end
      if (bus.sram_rd_en) begin
        if (exp_addrs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr %h expected no read", bus.sram_addr);
        end else begin
          ea = exp_addrs.pop_front();
          chk("sram_addr", bus.sram_addr, ea);
        end
      end
    end
  end

  // Waits (bounded) for the last beat; busy must stay high until that cycle.
  task automatic wait_last(output int c, output bit got);
    c   = 0;
    got = 1'b0;
    while (c < 20000 && !got) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 1) chk("err_one_cycle", bus.err, 1'b0);
      if (bus.last) got = 1'b1;
      else chk("busy_during", bus.busy, 1'b1);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL last_timeout: got no last after %0d cycles expected a last beat", c);
    end else begin
      chk("busy_last_cycle", bus.busy, 1'b0);
    end
  endtask

  // Caller sits 1 time unit after a rising edge. mode: 0 grant always, 1 random, 2 fixed_pat.
  task automatic run_req(input logic [AW-1:0] addr, input int size, input int mode);
    int  lines;
    int  ones;
    int  idx;
    int  c;
    bit  got;
    bit  g;
    logic pat[$];
    bus.mem_req        = 1'b1;
    bus.mem_start_addr = addr;
    bus.mem_size_bytes = SW'(size);
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    if (size == 0) begin
      chk("err_reject", bus.err, 1'b1);
      chk("busy_reject", bus.busy, 1'b0);
      @(posedge clk);
      #1;
      chk("err_reject_end", bus.err, 1'b0);
      chk("busy_reject_end", bus.busy, 1'b0);
      return;
    end
    lines = (size + 31) / 32;
    ones  = 0;
    idx   = 0;
    while (ones < lines) begin
      if (mode == 0) g = 1'b1;
      else if (mode == 2) g = (idx < fixed_pat.size()) ? fixed_pat[idx] : 1'b1;
      else g = ($urandom_range(0, 9) < 7);
      pat.push_back(g);
      if (g) ones++;
      idx++;
    end
    gnt_pat = pat;
    push_expect(addr[AW-1:5], size, lines);
    chk("err_accept", bus.err, (addr[4:0] != 5'd0));
    chk("busy_accept", bus.busy, 1'b1);
    wait_last(c, got);
    if (got) chk("latency", c, idx + 1);
    $display("xfer addr=%h size=%0d lines=%0d mode=%0d cycles=%0d", addr, size, lines, mode, c);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    bit got;
    logic [AW-1:0] a;
    int sz;
    bus.mem_req        = 1'b0;
    bus.mem_start_addr = '0;
    bus.mem_size_bytes = '0;
    #12;
    chk("rst_valid_busy_err", {bus.mem_valid, bus.busy, bus.err, bus.last}, 4'd0);
    chk("rst_lv_data", {bus.mem_last_valid, bus.mem_data}, 261'd0);
    chk("rst_sram", {bus.sram_rd_en, bus.sram_addr}, 15'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    run_req(19'h00040, 128, 0);
    run_req(19'h00000, 20, 0);
    fixed_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_req(19'h00000, 96, 2);
    run_req(19'h00100, 0, 0);
    run_req(19'h00013, 32, 0);
    run_req(19'h7FFE0, 100, 0);

    // Reset during the second beat of a four-beat transfer.
    bus.mem_req = 1'b1;
    bus.mem_start_addr = 19'h00040;
    bus.mem_size_bytes = SW'(128);
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    push_expect(14'd2, 128, 2);
    repeat (3) begin @(posedge clk); #1; end
    #5;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_busy_err", {bus.mem_valid, bus.busy, bus.err, bus.last}, 4'd0);
    chk("midrst_lv_data", {bus.mem_last_valid, bus.mem_data}, 261'd0);
    chk("midrst_sram", {bus.sram_rd_en, bus.sram_addr}, 15'd0);
    chk("midrst_drained", exp_beats.size() + exp_addrs.size(), 0);
    gnt_pat.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    run_req(19'h00040, 128, 0);

    // Request held high across two back-to-back transfers.
    bus.mem_req = 1'b1;
    bus.mem_start_addr = 19'h00100;
    bus.mem_size_bytes = SW'(64);
    @(posedge clk);
    #1;
    push_expect(14'h008, 64, 2);
    push_expect(14'h102, 64, 2);
    bus.mem_start_addr = 19'h02040;
    wait_last(c, got);
    if (got) chk("held_latency1", c, 3);
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    chk("held_accept_busy", bus.busy, 1'b1);
    wait_last(c, got);
    if (got) chk("held_latency2", c, 3);
    $display("held request pair done cycles=%0d", c);

    for (int i = 0; i < 30; i++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[4:0] = 5'd0;
      c = $urandom_range(0, 9);
      if (c == 0) sz = 0;
      else if (c < 3) sz = $urandom_range(1, 4096);
      else sz = $urandom_range(1, 200);
      run_req(a, sz, $urandom_range(0, 1));
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_beats.size() + exp_addrs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcc_mem_rd_responder.md
# fcc_mem_rd_responder

Memory-side responder for the FCC read interface (pic, wgt and bias ports): it serves one read request at a time by fetching 32-byte lines from a line-wide SRAM and streaming them back as `mem_valid` beats, with `last` and `mem_last_valid` marking the end of the transfer. It is the RTL counterpart of the behavioural memory model in the FCC bench, and one instance sits in front of each read port of the accelerator. SRAM access is arbitrated externally through `sram_gnt`.

## Interface
- `ADDR_WIDTH`, 19: byte address width.
- `SIZE_WIDTH`, 13: width of `mem_size_bytes`; maximum transfer is 4096 bytes.
- `LINE_BYTES`, 32: bytes per line and per beat. Fixed; not to be overridden.
- `clk`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `mem_req`  in  1: read request (level).
- `mem_start_addr`  in  ADDR_WIDTH: byte start address; must be 32-byte aligned.
- `mem_size_bytes`  in  SIZE_WIDTH: transfer length in bytes, 1..4096.
- `mem_valid`  out  1: beat valid.
- `mem_data`  out  256: beat data; byte k is at [8k+7:8k].
- `last`  out  1: final beat of the transfer.
- `mem_last_valid`  out  5: index of the last valid byte in the current beat.
- `busy`  out  1: a transfer is in progress.
- `err`  out  1: one-cycle pulse when a request is rejected or misaligned.
- `sram_rd_en`  out  1: SRAM line read strobe.
- `sram_addr`  out  ADDR_WIDTH-5: SRAM line address.
- `sram_rd_data`  in  256: SRAM read data, valid the cycle after `sram_rd_en`.
- `sram_gnt`  in  1: arbiter grant for this cycle.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE.**
  - `mem_req` is sampled only in IDLE.
  - On a rising edge with `mem_req`=1, capture the line address `mem_start_addr[ADDR_WIDTH-1:5]`.
  - Compute `lines` = (size+31)>>5 and `lv` = (size-1)&31, then go to ISSUE.
  - If size=0: no transfer, `err` pulses next cycle, stay in IDLE.
  - If `mem_start_addr[4:0]`≠0: `err` pulses, low bits are ignored, and the transfer proceeds from the aligned line.
- **ISSUE.**
  - `sram_rd_en` = ISSUE & `sram_gnt`. This is combinational from `sram_gnt`.
  - `sram_addr` = captured line address + issued-line count.
  - The issued count increments only on edges where `sram_rd_en`=1.
  - After the edge that issues line `lines`-1, go to DRAIN.
- **Return pipeline.**
  - A one-bit `rd_pend` flop is set on edges where `sram_rd_en`=1.
  - On the next edge, `sram_rd_data` is registered into `mem_data` with `mem_valid`=1.
- **Beat fields.**
  - Non-final beat: `mem_last_valid`=31, `last`=0.
  - Final beat: `mem_last_valid`=`lv`, `last`=1, and bytes above `lv` are forced to 0.
- **DRAIN.** Go to IDLE at the edge that presents the final beat.
- **busy.** High from the edge after acceptance until the edge that presents the final beat, i.e. `busy`=0 during the last-beat cycle.
- **Request held high.**
  - `mem_req` is level-sensitive.
  - If it is still 1 at the edge following the last-beat cycle, a new transfer is accepted.
  - The requester must drop `mem_req` by the edge at which it observes `last`.
  - `mem_req` changes while `busy`=1 are ignored.
- **Registered outputs.**
  - `mem_data`, `mem_valid`, `last`, `mem_last_valid` and `err` are registered.
  - When `mem_valid`=0, `mem_data`=0 and `mem_last_valid`=0.
- **Reset.**
  - Asserting `rst_n`=0 at any time, including mid-transfer, forces IDLE immediately.
  - All outputs go to 0: `mem_valid`, `last`, `mem_last_valid`, `mem_data`, `busy`, `err`, `sram_rd_en`, `sram_addr`.
  - Pending SRAM data is discarded, with no partial beats after reset release.

## Timing
- Edge E0 samples `mem_req`=1. `sram_rd_en` is first high in cycle E0→E1 if `sram_gnt`=1. The first `mem_valid` is high after edge E2.
- With `sram_gnt` held at 1:
  - `sram_rd_en` is asserted on `lines` consecutive cycles.
  - `mem_valid` is asserted on `lines` consecutive cycles, with `last` on the final one.
  - Total latency from the E0 edge to the last beat is `lines`+1 cycles.
- `sram_gnt`=0 inserts one `mem_valid`-low cycle per withheld cycle. Address and count hold; beat order is preserved.
- Minimum request-to-request spacing: a new request is accepted at the edge ending the last-beat cycle plus one.
- `err` is high for exactly one cycle, after the accepting edge.

## Test plan
- **Aligned transfer.** addr 0x00040, size 128, gnt=1 → 4 beats of SRAM lines 2..5, each `mem_last_valid`=31, `last` on beat 4, `busy` low in the beat-4 cycle.
- **Short transfer.** addr 0, size 20 → 1 beat, `mem_last_valid`=19, `last`=1, bytes 20..31 = 0.
- **Grant gaps.** size 96 with `sram_gnt` pattern 1,0,0,1,0,1 → 3 beats in order with gaps matching the grant holes, `sram_addr` values 0,1,2.
- **Rejected and misaligned requests.** size 0 → `err` one cycle, no `mem_valid`, `busy` stays 0. addr 0x00013, size 32 → `err` pulse, 1 beat from line 0.
- **Reset mid-transfer.** `rst_n` pulsed low during beat 2 of a 4-beat transfer → all outputs 0 immediately, no further beats, next request served normally.
- **Held request.** `mem_req` held at 1 across two 64-byte requests → second transfer accepted one cycle after the first `last`, 4 beats total, `last` twice.
